// File: rtl/sfr_bank_pkg.sv
// Shared defaults and address-map helpers for the SFR bank.
// Pointer k occupies registers 2k (low byte) and 2k+1 (high byte).
package sfr_bank_pkg;

  localparam int DATA_W_D   = 8;
  localparam int NUM_REGS_D = 32;
  localparam int NUM_PTRS_D = 5;
  localparam int NUM_OUT_D  = 18;
  localparam int NUM_IN_D   = 4;

  typedef enum int {
    PTR_SP  = 0,
    PTR_X   = 1,
    PTR_Y   = 2,
    PTR_Z   = 3,
    PTR_CSP = 4
  } ptr_idx_e;

  function automatic int ptr_lo_addr(input int k);
    return 2 * k;
  endfunction

endpackage

// File: rtl/sfr_bank_if.sv
// Register-file access bus: one write port and one registered read port.
interface sfr_bank_if #(
  parameter int AW     = 5,
  parameter int DATA_W = 8
);
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data
  );
endinterface

// File: rtl/sfr_ptr_unit.sv
// One memory pointer: merges byte writes, resolves inc/dec priority,
// produces the next pointer value and registers a one-cycle wrap pulse.
module sfr_ptr_unit #(
  parameter int DATA_W = 8,
  parameter int PTR_W  = 2 * DATA_W
) (
  input  logic              i_clock,
  input  logic              i_nreset,
  input  logic [PTR_W-1:0]  i_cur,
  input  logic              i_wr_lo,
  input  logic              i_wr_hi,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_inc,
  input  logic              i_dec,
  output logic [PTR_W-1:0]  o_nxt,
  output logic              o_wrap
);

  logic w_wrap_nxt;
  logic r_wrap;

  // A byte write always wins and silently drops any inc/dec that cycle.
  always_comb begin
    o_nxt      = i_cur;
    w_wrap_nxt = 1'b0;
    if (i_wr_lo) begin
      o_nxt[DATA_W-1:0] = i_wr_data;
    end else if (i_wr_hi) begin
      o_nxt[PTR_W-1:DATA_W] = i_wr_data;
    end else if (i_inc && i_dec) begin
      o_nxt = i_cur;
    end else if (i_inc) begin
      o_nxt      = i_cur + PTR_W'(1);
      w_wrap_nxt = &i_cur;
    end else if (i_dec) begin
      o_nxt      = i_cur - PTR_W'(1);
      w_wrap_nxt = ~|i_cur;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_nreset) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_wrap_nxt;
    end
  end

  assign o_wrap = r_wrap;

endmodule

// File: rtl/sfr_bank.sv
// Special function register bank: pointer pairs, exposed control registers,
// read-only input-capture registers, one write port and a registered read port.
module sfr_bank
  import sfr_bank_pkg::*;
#(
  parameter int DATA_W   = DATA_W_D,
  parameter int NUM_REGS = NUM_REGS_D,
  parameter int NUM_PTRS = NUM_PTRS_D,
  parameter int NUM_OUT  = NUM_OUT_D,
  parameter int NUM_IN   = NUM_IN_D,
  parameter int PTR_W    = 2 * DATA_W
) (
  input  logic                       i_clock,
  input  logic                       i_nreset,
  sfr_bank_if.slave                  bus,
  input  logic [NUM_PTRS-1:0]        i_ptr_inc,
  input  logic [NUM_PTRS-1:0]        i_ptr_dec,
  output logic [NUM_PTRS*PTR_W-1:0]  o_ptr_out,
  output logic [NUM_PTRS-1:0]        o_ptr_wrap,
  input  logic [NUM_IN*DATA_W-1:0]   i_sfr_in,
  output logic [NUM_OUT*DATA_W-1:0]  o_sfr_out
);

  localparam int AW       = $clog2(NUM_REGS);
  localparam int OUT_BASE = 2 * NUM_PTRS;
  localparam int IN_BASE  = NUM_REGS - NUM_IN;

  logic [DATA_W-1:0] r_regs    [NUM_REGS];
  logic [DATA_W-1:0] w_reg_nxt [NUM_REGS];
  logic [DATA_W-1:0] r_rd_data;
  logic [PTR_W-1:0]  w_ptr_cur [NUM_PTRS];
  logic [PTR_W-1:0]  w_ptr_nxt [NUM_PTRS];

  for (genvar k = 0; k < NUM_PTRS; k++) begin : g_ptr
    localparam int LO = ptr_lo_addr(k);
    logic w_wr_lo;
    logic w_wr_hi;

    assign w_ptr_cur[k] = {r_regs[LO+1], r_regs[LO]};
    assign w_wr_lo      = bus.wr_en && (bus.wr_addr == AW'(LO));
    assign w_wr_hi      = bus.wr_en && (bus.wr_addr == AW'(LO + 1));
    assign o_ptr_out[k*PTR_W +: PTR_W] = w_ptr_cur[k];

    sfr_ptr_unit #(
      .DATA_W (DATA_W),
      .PTR_W  (PTR_W)
    ) u_ptr (
      .i_clock   (i_clock),
      .i_nreset  (i_nreset),
      .i_cur     (w_ptr_cur[k]),
      .i_wr_lo   (w_wr_lo),
      .i_wr_hi   (w_wr_hi),
      .i_wr_data (bus.wr_data),
      .i_inc     (i_ptr_inc[k]),
      .i_dec     (i_ptr_dec[k]),
      .o_nxt     (w_ptr_nxt[k]),
      .o_wrap    (o_ptr_wrap[k])
    );
  end

  // Pointer registers take their unit's next value; capture registers load
  // unconditionally and are therefore never host-writable.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i < OUT_BASE) begin : g_ptr_byte
      if (i % 2 == 0) begin : g_lo
        assign w_reg_nxt[i] = w_ptr_nxt[i/2][DATA_W-1:0];
      end else begin : g_hi
        assign w_reg_nxt[i] = w_ptr_nxt[i/2][PTR_W-1:DATA_W];
      end
    end else if (i >= IN_BASE) begin : g_cap
      assign w_reg_nxt[i] = i_sfr_in[(i-IN_BASE)*DATA_W +: DATA_W];
    end else begin : g_gen
      assign w_reg_nxt[i] = (bus.wr_en && (bus.wr_addr == AW'(i))) ?
                            bus.wr_data : r_regs[i];
    end
  end

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
    assign o_sfr_out[j*DATA_W +: DATA_W] = r_regs[OUT_BASE+j];
  end

  always_ff @(posedge i_clock) begin
    if (!i_nreset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= w_reg_nxt[i];
      end
    end
  end

  // Read samples storage before this edge's updates land.
  always_ff @(posedge i_clock) begin
    if (!i_nreset) begin
      r_rd_data <= '0;
    end else if (bus.rd_en && (int'(bus.rd_addr) < NUM_REGS)) begin
      r_rd_data <= r_regs[bus.rd_addr];
    end else begin
      r_rd_data <= '0;
    end
  end

  assign bus.rd_data = r_rd_data;

endmodule
